// File: rtl/rect_cyl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rect_cyl_pkg
//  Description : Shared types and constants for the rectangular-to-cylindrical
//                sequencer (state encoding, widths, theta constants).
//  Revision    : 1.0 - initial release
// ============================================================================
package rect_cyl_pkg;

    localparam int unsigned COORD_W    = 16;
    localparam int unsigned ACC_W      = 32;
    localparam int unsigned SQRT_ITERS = 16;

    localparam logic [COORD_W-1:0] THETA_POS_HALF_PI = 16'h4000;
    localparam logic [COORD_W-1:0] THETA_NEG_HALF_PI = 16'hC000;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SQX  = 3'd1,
        SQY  = 3'd2,
        SQRT = 3'd3,
        DIV  = 3'd4,
        DONE = 3'd5
    } state_t;

    // Magnitude of a two's-complement coordinate; -32768 maps to 32768.
    function automatic logic [COORD_W-1:0] mag(input logic [COORD_W-1:0] v);
        return v[COORD_W-1] ? (~v + COORD_W'(1)) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rect_cyl_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : rect_cyl_seq_if
//  Description : Job/result handshake bundle between a coordinate source,
//                the sequencer and a result sink.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rect_cyl_seq_if;
    import rect_cyl_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] z;
    logic               out_valid;
    logic               out_ready;
    logic [COORD_W-1:0] r;
    logic [COORD_W-1:0] theta;
    logic [COORD_W-1:0] z_out;
    logic               busy;

    modport master (
        output in_valid, x, y, z, out_ready,
        input  in_ready, out_valid, r, theta, z_out, busy
    );

    modport slave (
        input  in_valid, x, y, z, out_ready,
        output in_ready, out_valid, r, theta, z_out, busy
    );

endinterface
`default_nettype wire

// File: rtl/rect_cyl_div.sv
`default_nettype none
// ============================================================================
//  Module      : rect_cyl_div
//  Description : Serial restoring divider on unsigned magnitudes. The start
//                edge performs the first step; o_done pulses one cycle after
//                the last of DIVIDEND_W steps.
//  Revision    : 1.0 - initial release
// ============================================================================
module rect_cyl_div
    import rect_cyl_pkg::*;
#(
    parameter int unsigned DIVIDEND_W = 30
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [DIVIDEND_W-1:0] i_dividend,
    input  logic [COORD_W-1:0]    i_divisor,
    output logic                  o_done,
    output logic [COORD_W-1:0]    o_quotient
);

    localparam int unsigned CNT_W = $clog2(DIVIDEND_W + 1);

    logic [COORD_W-1:0]    r_rem;
    logic [COORD_W-1:0]    r_dvs;
    logic [DIVIDEND_W-1:0] r_quo;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_run;
    logic                  r_done;

    logic [COORD_W-1:0]    w_rem_in;
    logic [COORD_W-1:0]    w_dvs_in;
    logic [DIVIDEND_W-1:0] w_quo_in;
    logic [COORD_W:0]      w_trial;
    logic                  w_fit;
    logic [COORD_W-1:0]    w_rem_nxt;
    logic [DIVIDEND_W-1:0] w_quo_nxt;

    // r_quo shifts dividend bits out of the top while quotient bits enter below.
    always_comb begin
        w_rem_in  = i_start ? '0         : r_rem;
        w_quo_in  = i_start ? i_dividend : r_quo;
        w_dvs_in  = i_start ? i_divisor  : r_dvs;
        w_trial   = {w_rem_in, w_quo_in[DIVIDEND_W-1]};
        w_fit     = (w_trial >= {1'b0, w_dvs_in});
        w_rem_nxt = w_fit ? COORD_W'(w_trial - {1'b0, w_dvs_in}) : w_trial[COORD_W-1:0];
        w_quo_nxt = {w_quo_in[DIVIDEND_W-2:0], w_fit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= '0;
            r_dvs  <= '0;
            r_quo  <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_rem <= w_rem_nxt;
                r_quo <= w_quo_nxt;
                r_dvs <= i_divisor;
                r_cnt <= CNT_W'(DIVIDEND_W - 1);
                r_run <= 1'b1;
            end else if (r_run) begin
                r_rem <= w_rem_nxt;
                r_quo <= w_quo_nxt;
                r_cnt <= r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done     = r_done;
    assign o_quotient = r_quo[COORD_W-1:0];

endmodule
`default_nettype wire

// File: rtl/rect_cyl_seq.sv
`default_nettype none
// ============================================================================
//  Module      : rect_cyl_seq
//  Description : Multicycle (x,y,z) -> (r,theta,z) converter sharing one
//                squaring multiplier between the squares and the serial sqrt.
//                Define THETA_EN to add the serial divider that produces theta;
//                otherwise theta is constant zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module rect_cyl_seq
    import rect_cyl_pkg::*;
#(
    parameter int unsigned FRAC_SHIFT = 14
) (
    input  logic           clk,
    input  logic           rst,
    rect_cyl_seq_if.slave  bus
);

    state_t             r_state;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic [COORD_W-1:0] r_z;
    logic [ACC_W-1:0]   r_acc;
    logic [COORD_W-1:0] r_res;
    logic [3:0]         r_bit;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;
    logic [COORD_W-1:0] r_r;
    logic [COORD_W-1:0] r_theta;
    logic [COORD_W-1:0] r_zout;

    logic [COORD_W-1:0]     w_onehot;
    logic [COORD_W-1:0]     w_cand;
    logic signed [COORD_W:0] w_mul_op;
    logic signed [ACC_W:0]  w_mul_ext;
    logic signed [ACC_W:0]  w_prod;
    logic                   w_fit;
    logic [COORD_W-1:0]     w_res_nxt;

    // The single multiplier squares x, then y, then each sqrt candidate.
    always_comb begin
        w_onehot = COORD_W'(1) << r_bit;
        w_cand   = r_res | w_onehot;
        case (r_state)
            SQX:     w_mul_op = {r_x[COORD_W-1], r_x};
            SQY:     w_mul_op = {r_y[COORD_W-1], r_y};
            default: w_mul_op = {1'b0, w_cand};
        endcase
    end

    assign w_mul_ext = (ACC_W+1)'(w_mul_op);
    assign w_prod    = w_mul_ext * w_mul_ext;
    assign w_fit     = ($unsigned(w_prod) <= {1'b0, r_acc});
    assign w_res_nxt = w_fit ? w_cand : r_res;

`ifdef THETA_EN
    localparam int unsigned DIV_W = COORD_W + FRAC_SHIFT;

    logic [COORD_W-1:0] w_x_mag;
    logic [COORD_W-1:0] w_y_mag;
    logic [DIV_W-1:0]   w_dividend;
    logic               w_div_start;
    logic               w_div_done;
    logic [COORD_W-1:0] w_quo;
    logic [COORD_W-1:0] w_theta;

    assign w_x_mag     = mag(r_x);
    assign w_y_mag     = mag(r_y);
    assign w_dividend  = DIV_W'(w_y_mag) << FRAC_SHIFT;
    // First divide step overlaps the last sqrt step so DIV lasts DIV_W cycles.
    assign w_div_start = (r_state == SQRT) && (r_bit == '0);

    rect_cyl_div #(
        .DIVIDEND_W (DIV_W)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_div_start),
        .i_dividend (w_dividend),
        .i_divisor  (w_x_mag),
        .o_done     (w_div_done),
        .o_quotient (w_quo)
    );

    always_comb begin
        if (r_x == '0)
            w_theta = ($signed(r_y) > 0) ? THETA_POS_HALF_PI : THETA_NEG_HALF_PI;
        else if (r_x[COORD_W-1] ^ r_y[COORD_W-1])
            w_theta = -w_quo;
        else
            w_theta = w_quo;
    end
`else
    logic [4:0] w_unused_frac;
    assign w_unused_frac = 5'(FRAC_SHIFT);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_acc       <= '0;
            r_res       <= '0;
            r_bit       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_r         <= '0;
            r_theta     <= '0;
            r_zout      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_x        <= bus.x;
                        r_y        <= bus.y;
                        r_z        <= bus.z;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= SQX;
                    end
                end
                SQX: begin
                    r_acc   <= w_prod[ACC_W-1:0];
                    r_state <= SQY;
                end
                SQY: begin
                    r_acc   <= r_acc + w_prod[ACC_W-1:0];
                    r_res   <= '0;
                    r_bit   <= 4'(SQRT_ITERS - 1);
                    r_state <= SQRT;
                end
                SQRT: begin
                    r_res <= w_res_nxt;
                    r_bit <= r_bit - 4'd1;
                    if (r_bit == '0) begin
`ifdef THETA_EN
                        r_state     <= DIV;
`else
                        r_r         <= w_res_nxt;
                        r_theta     <= '0;
                        r_zout      <= r_z;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
`endif
                    end
                end
`ifdef THETA_EN
                DIV: begin
                    if (w_div_done) begin
                        r_r         <= r_res;
                        r_theta     <= w_theta;
                        r_zout      <= r_z;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.r         = r_r;
    assign bus.theta     = r_theta;
    assign bus.z_out     = r_zout;

endmodule
`default_nettype wire

// File: tb/tb_rect_cyl_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rect_cyl_seq
//  Description : Directed bench for rect_cyl_seq with a result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rect_cyl_seq;
    import rect_cyl_pkg::*;

`ifdef THETA_EN
    localparam int N = 48;
`else
    localparam int N = 18;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    rect_cyl_seq_if bus();

    rect_cyl_seq #(.FRAC_SHIFT(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] r;
        logic [15:0] theta;
        logic [15:0] z;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [15:0] theta_exp(input logic [15:0] t);
`ifdef THETA_EN
        return t;
`else
        return 16'h0000;
`endif
    endfunction

    // Results are checked here whenever the sink handshake is about to occur.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("r",     bus.r,     e.r);
                check("theta", bus.theta, e.theta);
                check("z_out", bus.z_out, e.z);
            end
        end
    end

    task automatic issue(input logic [15:0] xi, input logic [15:0] yi, input logic [15:0] zi,
                         input logic [15:0] er, input logic [15:0] et, input logic [15:0] ez,
                         input bit track);
        int g = 0;
        while (!bus.in_ready && g < 200) begin
            @(posedge clk); #1; g++;
        end
        check("in_ready_before_accept", bus.in_ready, 1);
        bus.x = xi; bus.y = yi; bus.z = zi; bus.in_valid = 1'b1;
        if (track) sb.push_back('{r: er, theta: theta_exp(et), z: ez});
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.x = 16'hDEAD; bus.y = 16'hBEEF; bus.z = 16'h1234;
        check("busy_after_accept", bus.busy, 1);
    endtask

    task automatic wait_out();
        int lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!bus.out_valid && lat < 200);
        check("latency", lat, N);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] bx [3];
        logic [15:0] by [3];
        logic [15:0] bz [3];
        logic [15:0] br [3];
        logic [15:0] bt [3];
        int g;

        bus.in_valid = 1'b0; bus.x = '0; bus.y = '0; bus.z = '0; bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready",  bus.in_ready,  1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy",      bus.busy,      0);
        check("rst_r",         bus.r,         0);
        check("rst_theta",     bus.theta,     0);
        check("rst_z_out",     bus.z_out,     0);

        issue(16'd3,     16'd4,     16'd7,     16'd5,     16'h5555, 16'd7,     1); wait_out();
        issue(16'hFFFD,  16'd4,     16'd0,     16'd5,     16'hAAAB, 16'd0,     1); wait_out();
        issue(16'd0,     16'd5,     16'd1,     16'd5,     16'h4000, 16'd1,     1); wait_out();
        issue(16'd0,     16'd0,     16'd0,     16'd0,     16'hC000, 16'd0,     1); wait_out();
        issue(16'h8000,  16'h8000,  16'hFFFF,  16'd46340, 16'h4000, 16'hFFFF,  1); wait_out();

        // Sink stalls: result must hold and new offers must be ignored.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        issue(16'd8, 16'd6, 16'd3, 16'd10, 16'h3000, 16'd3, 1);
        wait_out();
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1; bus.x = 16'd1; bus.y = 16'd2; bus.z = 16'd9;
            @(posedge clk); #1;
            check("hold_r",         bus.r,        16'd10);
            check("hold_theta",     bus.theta,    theta_exp(16'h3000));
            check("hold_z_out",     bus.z_out,    16'd3);
            check("hold_in_ready",  bus.in_ready, 0);
            check("hold_out_valid", bus.out_valid, 1);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_in_ready",  bus.in_ready,  1);
        check("release_out_valid", bus.out_valid, 0);

        // Reset lands on the 10th edge after accept; the job must vanish.
        issue(16'd1, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_busy",      bus.busy,      0);
        check("midrst_r",         bus.r,         0);
        check("midrst_theta",     bus.theta,     0);
        check("midrst_z_out",     bus.z_out,     0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_in_ready",  bus.in_ready,  1);
        issue(16'd6, 16'd8, 16'd2, 16'd10, 16'h5555, 16'd2, 1); wait_out();

        // Back-to-back with in_valid and out_ready held high.
        bx = '{16'd5,  16'hFFFA, 16'd7};
        by = '{16'd12, 16'hFFF8, 16'd0};
        bz = '{16'd9,  16'd4,    16'd5};
        br = '{16'd13, 16'd10,   16'd7};
        bt = '{16'h9999, 16'h5555, 16'h0000};
        bus.in_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            g = 0;
            while (!bus.in_ready && g < 200) begin
                @(posedge clk); #1; g++;
            end
            if (j > 0) check("accept_gap", g, N + 1);
            bus.x = bx[j]; bus.y = by[j]; bus.z = bz[j];
            sb.push_back('{r: br[j], theta: theta_exp(bt[j]), z: bz[j]});
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;

        g = 0;
        while (sb.size() != 0 && g < 200) begin
            @(posedge clk); #1; g++;
        end
        check("scoreboard_drained", sb.size(), 0);
        repeat (N + 5) @(posedge clk);
        #1;
        check("idle_out_valid", bus.out_valid, 0);
        check("idle_in_ready",  bus.in_ready,  1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
